// File: rtl/rom_copy_engine.sv
// Boot ROM to destination memory copy engine: streams a block of ROM words through a 2-entry FIFO onto a req/gnt write bus.
// Optional build macro ROM_COPY_CHECKSUM_EN adds a running checksum_o of the written words.
module rom_copy_engine #(
    parameter int ADDR_WIDTH     = 11,
    parameter int DATA_WIDTH     = 32,
    parameter int DST_ADDR_WIDTH = 32
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      start_i,
    input  logic [ADDR_WIDTH-1:0]     src_base_i,
    input  logic [DST_ADDR_WIDTH-1:0] dst_base_i,
    input  logic [ADDR_WIDTH:0]       len_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      rom_cen_o,
    output logic [ADDR_WIDTH-1:0]     rom_a_o,
    input  logic [DATA_WIDTH-1:0]     rom_q_i,
    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [DST_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0]     mem_wdata_o,
    input  logic                      mem_gnt_i,
    output logic [1:0]                dbg_state_o
`ifdef ROM_COPY_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0]     checksum_o
`endif
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    localparam logic [ADDR_WIDTH:0]       ONE       = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [DST_ADDR_WIDTH-1:0] ADDR_STEP = DST_ADDR_WIDTH'(DATA_WIDTH / 8);

    state_t                    state;
    logic [ADDR_WIDTH-1:0]     src_base;
    logic [ADDR_WIDTH-1:0]     rom_a_q;
    logic [ADDR_WIDTH:0]       len;
    logic [ADDR_WIDTH:0]       issued;
    logic [ADDR_WIDTH:0]       written;
    logic [DST_ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]     fifo0;
    logic [DATA_WIDTH-1:0]     fifo1;
    logic                      wr_ptr;
    logic                      rd_ptr;
    logic                      inflight;
    logic [1:0]                fifo_count;
    logic                      room;
    logic                      issue;
    logic                      pop;

    // Destination handshake: a word transfers in any cycle where mem_req_o and
    // mem_gnt_i are both high; req, address and data hold steady until then.
    always_comb begin
        mem_req_o   = (fifo_count != 2'd0);
        mem_we_o    = mem_req_o;
        mem_wdata_o = rd_ptr ? fifo1 : fifo0;
        mem_addr_o  = addr_q;
        pop         = mem_req_o & mem_gnt_i;
        // A pop this cycle frees a slot, so issue can continue at full rate.
        room        = ({1'b0, fifo_count} + {2'b00, inflight}) < 3'd2;
        issue       = (state == RUN) && (issued < len) && (room || pop);
        rom_cen_o   = ~issue;
        rom_a_o     = issue ? (src_base + issued[ADDR_WIDTH-1:0]) : rom_a_q;
        busy_o      = (state == RUN);
        done_o      = (state == DONE);
        dbg_state_o = state;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            src_base   <= '0;
            rom_a_q    <= '0;
            len        <= '0;
            issued     <= '0;
            written    <= '0;
            addr_q     <= '0;
            fifo0      <= '0;
            fifo1      <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            inflight   <= 1'b0;
            fifo_count <= 2'd0;
`ifdef ROM_COPY_CHECKSUM_EN
            checksum_o <= '0;
`endif
        end else begin
            inflight <= issue;
            if (issue) begin
                rom_a_q <= rom_a_o;
                issued  <= issued + ONE;
            end
            // ROM data for last cycle's read is on rom_q_i now.
            if (inflight) begin
                if (wr_ptr) fifo1 <= rom_q_i;
                else        fifo0 <= rom_q_i;
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr  <= ~rd_ptr;
                addr_q  <= addr_q + ADDR_STEP;
                written <= written + ONE;
`ifdef ROM_COPY_CHECKSUM_EN
                checksum_o <= checksum_o + mem_wdata_o;
`endif
            end
            case ({inflight, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase

            case (state)
                IDLE: begin
                    if (start_i) begin
                        src_base <= src_base_i;
                        len      <= len_i;
                        addr_q   <= dst_base_i;
                        issued   <= '0;
                        written  <= '0;
`ifdef ROM_COPY_CHECKSUM_EN
                        checksum_o <= '0;
`endif
                        state    <= (len_i == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (pop && ((written + ONE) == len)) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/rom_copy_engine.md
# rom_copy_engine

Initiator-side master for the synchronous boot ROM port. On a start command it reads a contiguous block of words from the ROM and writes them to a destination memory over a request/grant bus. It sits between the SoC boot controller and the boot ROM, and sustains one word per cycle when the destination grants continuously.

## Interface
Parameters:
- ADDR_WIDTH, 11, ROM word-address width.
- DATA_WIDTH, 32, ROM and destination data width; must be a multiple of 8.
- DST_ADDR_WIDTH, 32, destination byte-address width.

Ports:
- CLK  in  1  single clock; all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- start_i  in  1  start command; sampled only in IDLE.
- src_base_i  in  ADDR_WIDTH  first ROM word address.
- dst_base_i  in  DST_ADDR_WIDTH  first destination byte address, word aligned.
- len_i  in  ADDR_WIDTH+1  number of words to copy, 0..2^ADDR_WIDTH.
- busy_o  out  1  high while a copy is in progress.
- done_o  out  1  one-cycle completion pulse.
- rom_cen_o  out  1  ROM chip enable, active low.
- rom_a_o  out  ADDR_WIDTH  ROM word address.
- rom_q_i  in  DATA_WIDTH  ROM data, valid the cycle after rom_cen_o is low.
- mem_req_o  out  1  destination write request.
- mem_we_o  out  1  tied high whenever mem_req_o is high.
- mem_addr_o  out  DST_ADDR_WIDTH  destination byte address.
- mem_wdata_o  out  DATA_WIDTH  write data.
- mem_gnt_i  in  1  destination grant; a transfer completes when req and gnt are both high.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: on start_i=1, latch the bases and len_i, and clear the issue and write counters.
  - len_i=0: go to DONE.
  - Otherwise: go to RUN.
- RUN issues a ROM read (rom_cen_o=0, rom_a_o = src_base + issued, modulo 2^ADDR_WIDTH) when both hold:
  - issued < len.
  - fifo_count + inflight < 2, or a destination pop happens in the same cycle.
- Read data is captured from rom_q_i into a 2-entry FIFO in the cycle after the issue.
- mem_req_o is high whenever the FIFO is non-empty.
  - mem_wdata_o is the FIFO head.
  - mem_addr_o = dst_base + written*(DATA_WIDTH/8), modulo 2^DST_ADDR_WIDTH.
  - Request, address and data stay stable until granted.
- Each req&gnt pops the FIFO and increments written. When written reaches len, go to DONE.
- DONE lasts one cycle, with done_o=1 and busy_o=0, then returns to IDLE.
- start_i in RUN or DONE is ignored.
- ROM address wraps modulo 2^ADDR_WIDTH; the destination address wraps modulo 2^DST_ADDR_WIDTH. Neither wrap is flagged.
- When not issuing, rom_cen_o=1 and rom_a_o holds its last value.

## Timing
- Reset values: busy_o=0, done_o=0, rom_cen_o=1, rom_a_o=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0. The state returns to IDLE with the FIFO emptied.
- Reset asserted mid-copy aborts immediately. mem_req_o is dropped with no completion, and done_o is not pulsed.
- busy_o goes high the cycle after start_i is sampled (cycle 1).
- With mem_gnt_i held at 1 and start sampled at edge 0:
  - First ROM read in cycle 1.
  - First mem_req_o in cycle 3.
  - Last handshake in cycle 2+N.
  - done_o in cycle 3+N.
- With continuous grant, one word moves per cycle with no bubbles.
- Grant stalls back-pressure ROM issue. At most 2 words are buffered or in flight, and no ROM data is lost.
- len_i=0: done_o in cycle 1, with no ROM or destination activity.

## Configuration
- ROM_COPY_CHECKSUM_EN defined:
  - Adds output checksum_o [DATA_WIDTH-1:0], reset to 0 and cleared on an accepted start.
  - On every handshake, checksum_o accumulates the sum of written words modulo 2^DATA_WIDTH.
  - The final value is valid when done_o is high and holds until the next start.
- ROM_COPY_CHECKSUM_EN undefined: the port and its logic are absent, and all other behaviour is identical.

## Test plan
- Reset then idle: all outputs at their reset values, rom_cen_o=1 throughout.
- src=0x010, dst=0x1000_0000, len=4, gnt=1: ROM reads 0x010..0x013 in cycles 1–4; writes to 0x1000_0000, _0004, _0008, _000C in cycles 3–6; done_o in cycle 7.
- len=3 with gnt low for 5 cycles on the second word: only 2 outstanding reads, correct data order, mem_addr_o/mem_wdata_o stable while stalled.
- src=0x7FE, len=4: ROM addresses 0x7FE, 0x7FF, 0x000, 0x001.
- len=0: done_o in cycle 1, no rom_cen_o low, no mem_req_o. A second start_i pulse mid-copy is ignored.
- RST asserted during word 2 of an 8-word copy: outputs return to reset values asynchronously, no done_o. A new copy then runs correctly. With ROM_COPY_CHECKSUM_EN, ROM words 1,2,3,4 give checksum_o=10 at done_o.
